mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word and RAM-status types for the memory subsystem
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one shared RAM port to data or instruction requests, bounding instruction starvation
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate
);

   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DGNT = 2'd1,
      IGNT = 2'd2
   } arb_state_t;

   arb_state_t    state, next, pick;
   logic [SW-1:0] starve, starve_next;
   logic          dreq, done, starved;

   assign dreq    = dREN | dWEN;
   assign done    = (state != IDLE) && (ramstate == ACCESS);
   assign starved = iREN && (starve_next == SW'(STARVE_MAX));

   // starvation count of data completions while an instruction fetch is pending
   always_comb begin
      starve_next = !iREN                                                      ? '0
                  : (done && state == IGNT)                                    ? '0
                  : (done && state == DGNT && starve != SW'(STARVE_MAX))       ? starve + 1'b1
                  :                                                              starve;
   end

   // arbitrate on the updated count so the forced instruction grant follows the last allowed data grant
   always_comb begin
      pick = (dreq && !starved) ? DGNT : iREN ? IGNT : IDLE;
      next = (state == IDLE)                     ? pick
           : (state == DGNT && (done || !dreq))  ? pick
           : (state == IGNT && (done || !iREN))  ? pick
           :                                       state;
   end

   // grant state and starvation counter; reset abandons any access in flight
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         starve <= '0;
      end else begin
         state  <= next;
         starve <= starve_next;
      end
   end

   // RAM port and wait decode from the registered grant; data fields pass straight through
   always_comb begin
      ramaddr  = (state == DGNT) ? daddr : (state == IGNT) ? iaddr : '0;
      ramstore = (state == DGNT) ? dstore : '0;
      ramWEN   = (state == DGNT) && dWEN;
      ramREN   = ((state == DGNT) && dREN && !dWEN) || (state == IGNT);
      dwait    = !((state == DGNT) && (ramstate == ACCESS));
      iwait    = !((state == IGNT) && (ramstate == ACCESS));
      iload    = ramload;
      dload    = ramload;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, grant-order and reset sequences, and randomized model comparison
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int SMAX = 3;
   localparam logic [31:0] IA = 32'h0000_0100;
   localparam logic [31:0] DA = 32'h0000_0040;
   localparam logic [31:0] DS = 32'hDEAD_BEEF;
   localparam logic [31:0] RL = 32'h8C22_0010;

   logic        CLK = 1'b0, nRST = 1'b0;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
   ramstate_t   ramstate = FREE;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.STARVE_MAX(SMAX)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ir, dr, dw;
      ramstate_t   rs;
      logic        er, ew, eiw, edw;
      logic [31:0] ea, es;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      ramstate = FREE;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
   endtask

   // behavioural reference: who owns the RAM and how many data completions the fetch has waited through
   int own, cnt;

   task automatic model_check();
      logic fin;
      chk("rnd_ramREN", 32'(ramREN), 32'((own == 1 && dREN && !dWEN) || own == 2));
      chk("rnd_ramWEN", 32'(ramWEN), 32'(own == 1 && dWEN));
      chk("rnd_ramaddr", ramaddr, own == 1 ? daddr : own == 2 ? iaddr : 32'h0);
      chk("rnd_ramstore", ramstore, own == 1 ? dstore : 32'h0);
      chk("rnd_dwait", 32'(dwait), 32'(!(own == 1 && ramstate == ACCESS)));
      chk("rnd_iwait", 32'(iwait), 32'(!(own == 2 && ramstate == ACCESS)));
      chk("rnd_dload", dload, ramload);
      chk("rnd_iload", iload, ramload);
      fin = (own != 0) && (ramstate == ACCESS);
      if (!iREN) cnt = 0;
      else if (fin && own == 2) cnt = 0;
      else if (fin && own == 1 && cnt < SMAX) cnt++;
      if (own == 0 || fin || (own == 1 && !(dREN || dWEN)) || (own == 2 && !iREN))
         own = ((dREN || dWEN) && !(iREN && cnt >= SMAX)) ? 1 : iREN ? 2 : 0;
   endtask

   initial begin
      logic [31:0] gexp[8];
      tv[0]  = '{1'b0, 1'b0, 1'b0, FREE,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
      tv[1]  = '{1'b1, 1'b0, 1'b0, BUSY,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
      tv[2]  = '{1'b1, 1'b0, 1'b0, BUSY,   1'b1, 1'b0, 1'b1, 1'b1, IA,    32'h0};
      tv[3]  = '{1'b1, 1'b0, 1'b0, BUSY,   1'b1, 1'b0, 1'b1, 1'b1, IA,    32'h0};
      tv[4]  = '{1'b1, 1'b0, 1'b0, ACCESS, 1'b1, 1'b0, 1'b0, 1'b1, IA,    32'h0};
      tv[5]  = '{1'b0, 1'b0, 1'b0, FREE,   1'b1, 1'b0, 1'b1, 1'b1, IA,    32'h0};
      tv[6]  = '{1'b0, 1'b0, 1'b0, FREE,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
      tv[7]  = '{1'b1, 1'b1, 1'b0, FREE,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
      tv[8]  = '{1'b1, 1'b1, 1'b0, ACCESS, 1'b1, 1'b0, 1'b1, 1'b0, DA,    DS};
      tv[9]  = '{1'b1, 1'b1, 1'b1, ACCESS, 1'b0, 1'b1, 1'b1, 1'b0, DA,    DS};
      tv[10] = '{1'b1, 1'b1, 1'b1, ACCESS, 1'b0, 1'b1, 1'b1, 1'b0, DA,    DS};
      tv[11] = '{1'b1, 1'b1, 1'b0, ACCESS, 1'b1, 1'b0, 1'b0, 1'b1, IA,    32'h0};
      tv[12] = '{1'b0, 1'b1, 1'b0, FREE,   1'b1, 1'b0, 1'b1, 1'b1, DA,    DS};
      tv[13] = '{1'b0, 1'b1, 1'b0, ERROR,  1'b1, 1'b0, 1'b1, 1'b1, DA,    DS};
      tv[14] = '{1'b0, 1'b0, 1'b0, BUSY,   1'b0, 1'b0, 1'b1, 1'b1, DA,    DS};
      tv[15] = '{1'b0, 1'b0, 1'b0, FREE,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};

      iaddr = IA; daddr = DA; dstore = DS; ramload = RL;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         iREN = tv[i].ir; dREN = tv[i].dr; dWEN = tv[i].dw; ramstate = tv[i].rs;
         #1;
         chk($sformatf("tv%0d_ramREN", i), 32'(ramREN), 32'(tv[i].er));
         chk($sformatf("tv%0d_ramWEN", i), 32'(ramWEN), 32'(tv[i].ew));
         chk($sformatf("tv%0d_iwait", i), 32'(iwait), 32'(tv[i].eiw));
         chk($sformatf("tv%0d_dwait", i), 32'(dwait), 32'(tv[i].edw));
         chk($sformatf("tv%0d_ramaddr", i), ramaddr, tv[i].ea);
         chk($sformatf("tv%0d_ramstore", i), ramstore, tv[i].es);
         chk($sformatf("tv%0d_iload", i), iload, RL);
      end

      // back-to-back completions: three data grants then a forced instruction grant, twice
      gexp = '{DA, DA, DA, IA, DA, DA, DA, IA};
      do_reset();
      @(negedge CLK);
      iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = ACCESS;
      #1 chk("seq_idle_first", 32'(ramREN), 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         #1 chk($sformatf("seq_grant%0d", k), ramaddr, gexp[k]);
      end

      // reset in the middle of a busy instruction grant
      @(negedge CLK);
      dREN = 1'b0; ramstate = BUSY;
      repeat (3) @(negedge CLK);
      #1 chk("rst_pre_ramREN", 32'(ramREN), 32'h1);
      chk("rst_pre_ramaddr", ramaddr, IA);
      #1 nRST = 1'b0;
      #1 chk("rst_async_ramREN", 32'(ramREN), 32'h0);
      chk("rst_async_ramaddr", ramaddr, 32'h0);
      chk("rst_async_iwait", 32'(iwait), 32'h1);
      @(negedge CLK);
      ramstate = ACCESS;
      #1 chk("rst_held_iwait", 32'(iwait), 32'h1);
      @(negedge CLK);
      nRST = 1'b1; ramstate = BUSY;
      #1 chk("rst_release_idle", 32'(ramREN), 32'h0);
      @(negedge CLK);
      #1 chk("rst_first_grant", 32'(ramREN), 32'h1);
      iREN = 1'b0;

      // randomized traffic against the reference model
      do_reset();
      own = 0; cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge CLK);
         iREN = ($urandom_range(0, 9) < 7);
         dREN = 1'($urandom);
         dWEN = ($urandom_range(0, 3) == 0);
         ramstate = ramstate_t'($urandom_range(0, 3));
         iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
         #1 model_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
